// File: rtl/char_disp_pkg.sv
// Shared types and helpers for the character-line display path.
// Holds ROM geometry, the fetch state encoding and the scanline-to-glyph-row mapping.
package char_disp_pkg;

  localparam int ROM_AW     = 9;
  localparam int GLYPH_W    = 8;
  localparam int GLYPH_ROWS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // 11-bit compare so a box near the bottom of the 10-bit range cannot wrap
  function automatic logic calc_in_box(input logic [9:0] y, input logic [9:0] y_box,
                                       input int scale_log2);
    logic [10:0] y_s;
    logic [10:0] lo_s;
    logic [10:0] hi_s;
    y_s  = {1'b0, y};
    lo_s = {1'b0, y_box};
    hi_s = lo_s + (11'(GLYPH_ROWS) << scale_log2);
    return (y_s >= lo_s) && (y_s < hi_s);
  endfunction

  function automatic logic [2:0] calc_glyph_row(input logic [9:0] y, input logic [9:0] y_box,
                                                input int scale_log2);
    logic [10:0] diff_s;
    diff_s = ({1'b0, y} - {1'b0, y_box}) >> scale_log2;
    return diff_s[2:0];
  endfunction

endpackage

// File: rtl/char_row_buf.sv
// Double-buffered glyph row store: the fetcher fills the back bank while the
// display reads the front bank; swap copies back to front in one cycle.
module char_row_buf import char_disp_pkg::*; #(
  parameter int unsigned NUM_CHARS = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [3:0]                     wr_idx,
  input  logic [GLYPH_W-1:0]             wr_data,
  input  logic                           swap,
  output logic [NUM_CHARS*GLYPH_W-1:0]   row_bits
);

  logic [GLYPH_W-1:0]           back_r [NUM_CHARS];
  logic [NUM_CHARS*GLYPH_W-1:0] back_flat_s;

  // flatten the back bank into front-buffer lane order
  always_comb begin
    back_flat_s = '0;
    for (int i = 0; i < int'(NUM_CHARS); i++) begin
      back_flat_s[i*GLYPH_W +: GLYPH_W] = back_r[i];
    end
  end

  // back bank write port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) begin
        back_r[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) begin
        if (wr_idx == 4'(i)) begin
          back_r[i] <= wr_data;
        end
      end
    end
  end

  // front bank, updated only on swap
  always_ff @(posedge clk) begin
    if (rst) begin
      row_bits <= '0;
    end else if (swap) begin
      row_bits <= back_flat_s;
    end
  end

endmodule

// File: rtl/char_row_fetch_sched.sv
// Per-scanline font ROM fetch scheduler for one text line of NUM_CHARS boxes.
// Optional macro CHAR_FETCH_OVERRUN_CNT_EN adds overrun_cnt and overrun_clr.
module char_row_fetch_sched import char_disp_pkg::*; #(
  parameter int unsigned NUM_CHARS  = 8,
  parameter logic [9:0]  Y_BOX      = 10'd32,
  parameter int          SCALE_LOG2 = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          line_start,
  input  logic [9:0]                    line_y,
  input  logic                          slot_wr_en,
  input  logic [3:0]                    slot_wr_idx,
  input  logic [ROM_AW-1:0]             slot_wr_base,
  input  logic                          rom_gnt,
  output logic                          rom_en,
  output logic [ROM_AW-1:0]             rom_addr,
  input  logic [GLYPH_W-1:0]            rom_data,
  output logic [NUM_CHARS*GLYPH_W-1:0]  row_bits,
  output logic                          line_active,
  output logic                          fetch_busy,
`ifdef CHAR_FETCH_OVERRUN_CNT_EN
  input  logic                          overrun_clr,
  output logic [7:0]                    overrun_cnt,
`endif
  output logic                          overrun
);

  fetch_state_e state_r;
  logic [5:0]   slot_base_r [NUM_CHARS];
  logic [3:0]   slot_cnt_r;
  logic [2:0]   row_r;
  logic         back_valid_r;
  logic         cap_vld_r;
  logic [3:0]   cap_idx_r;

  logic         accept_s;
  logic         abort_s;
  logic         start_s;
  logic         in_box_s;
  logic [2:0]   new_row_s;
  logic [3:0]   tgt_idx_s;
  logic [5:0]   tgt_base_s;
  logic         unused_s;

  assign unused_s = ^slot_wr_base[2:0];

  // slot table; writes to indices beyond NUM_CHARS are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) begin
        slot_base_r[i] <= 6'd0;
      end
    end else if (slot_wr_en) begin
      for (int i = 0; i < int'(NUM_CHARS); i++) begin
        if (slot_wr_idx == 4'(i)) begin
          slot_base_r[i] <= slot_wr_base[8:3];
        end
      end
    end
  end

  // next address selection; a same-cycle slot write is forwarded so it shows up next cycle
  always_comb begin
    accept_s   = rom_en && rom_gnt;
    abort_s    = line_start && (state_r != IDLE);
    in_box_s   = calc_in_box(line_y, Y_BOX, SCALE_LOG2);
    new_row_s  = calc_glyph_row(line_y, Y_BOX, SCALE_LOG2);
    start_s    = line_start && in_box_s;
    tgt_idx_s  = start_s ? 4'd0 : (accept_s ? slot_cnt_r + 4'd1 : slot_cnt_r);
    tgt_base_s = 6'd0;
    for (int i = 0; i < int'(NUM_CHARS); i++) begin
      tgt_base_s = (tgt_idx_s == 4'(i)) ? slot_base_r[i] : tgt_base_s;
    end
    if (slot_wr_en && (slot_wr_idx == tgt_idx_s)) begin
      tgt_base_s = slot_wr_base[8:3];
    end else begin
      tgt_base_s = tgt_base_s;
    end
  end

  // fetch sequencer with registered ROM request, busy and line status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      slot_cnt_r   <= 4'd0;
      row_r        <= 3'd0;
      back_valid_r <= 1'b0;
      cap_vld_r    <= 1'b0;
      cap_idx_r    <= 4'd0;
      rom_en       <= 1'b0;
      rom_addr     <= '0;
      line_active  <= 1'b0;
      fetch_busy   <= 1'b0;
    end else begin
      cap_vld_r <= accept_s && !line_start;
      cap_idx_r <= slot_cnt_r;
      if (line_start) begin
        line_active  <= abort_s ? 1'b0 : back_valid_r;
        back_valid_r <= in_box_s;
        slot_cnt_r   <= 4'd0;
        if (in_box_s) begin
          state_r    <= FETCH;
          fetch_busy <= 1'b1;
          rom_en     <= 1'b1;
          rom_addr   <= {tgt_base_s, new_row_s};
          row_r      <= new_row_s;
        end else begin
          state_r    <= IDLE;
          fetch_busy <= 1'b0;
          rom_en     <= 1'b0;
        end
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          FETCH: begin
            rom_addr <= {tgt_base_s, row_r};
            if (accept_s) begin
              if (slot_cnt_r == 4'(NUM_CHARS - 1)) begin
                state_r <= DRAIN;
                rom_en  <= 1'b0;
              end else begin
                slot_cnt_r <= slot_cnt_r + 4'd1;
              end
            end
          end
          DRAIN: begin
            state_r    <= IDLE;
            fetch_busy <= 1'b0;
          end
          default: begin
            state_r    <= IDLE;
            rom_en     <= 1'b0;
            fetch_busy <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CHAR_FETCH_OVERRUN_CNT_EN
  // sticky overrun flag plus saturating event count; clear beats a new event
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else if (overrun_clr) begin
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else if (abort_s) begin
      overrun <= 1'b1;
      if (overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end
`else
  // sticky overrun flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (abort_s) begin
      overrun <= 1'b1;
    end
  end
`endif

  char_row_buf #(.NUM_CHARS(NUM_CHARS)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (cap_vld_r && !abort_s),
    .wr_idx   (cap_idx_r),
    .wr_data  (rom_data),
    .swap     (line_start && (state_r == IDLE)),
    .row_bits (row_bits)
  );

endmodule

// File: tb/tb_char_row_fetch_sched.sv
// Directed self-checking bench for char_row_fetch_sched with a behavioural font ROM.
// Exercises the CHAR_FETCH_OVERRUN_CNT_EN counter only when that macro is defined.
module tb_char_row_fetch_sched;

  localparam int NC = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          line_start = 1'b0;
  logic [9:0]    line_y = 10'd0;
  logic          slot_wr_en = 1'b0;
  logic [3:0]    slot_wr_idx = 4'd0;
  logic [8:0]    slot_wr_base = 9'd0;
  logic          rom_gnt = 1'b1;
  logic          rom_en;
  logic [8:0]    rom_addr;
  logic [7:0]    rom_data = 8'd0;
  logic [NC*8-1:0] row_bits;
  logic          line_active;
  logic          fetch_busy;
  logic          overrun;
`ifdef CHAR_FETCH_OVERRUN_CNT_EN
  logic          overrun_clr = 1'b0;
  logic [7:0]    overrun_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [8:0] base_tb [NC];

  char_row_fetch_sched #(.NUM_CHARS(NC), .Y_BOX(10'd32), .SCALE_LOG2(2)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .line_y(line_y),
    .slot_wr_en(slot_wr_en), .slot_wr_idx(slot_wr_idx), .slot_wr_base(slot_wr_base),
    .rom_gnt(rom_gnt), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .row_bits(row_bits), .line_active(line_active), .fetch_busy(fetch_busy),
`ifdef CHAR_FETCH_OVERRUN_CNT_EN
    .overrun_clr(overrun_clr), .overrun_cnt(overrun_cnt),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [8:0] a);
    logic [7:0] v;
    v = 8'(a[7:0] * 8'd7) + 8'd3;
    return a[8] ? (v ^ 8'h5A) : v;
  endfunction

  // synchronous ROM; ungranted cycles return a junk pattern
  always @(posedge clk) rom_data <= (rom_en && rom_gnt) ? rom_val(rom_addr) : 8'hEE;

  function automatic logic [8:0] exp_addr(input int slot, input int row);
    logic [8:0] b;
    b = base_tb[slot];
    return {b[8:3], 3'(row)};
  endfunction

  function automatic logic [NC*8-1:0] exp_bits(input int row);
    logic [NC*8-1:0] v;
    for (int i = 0; i < NC; i++) v[i*8 +: 8] = rom_val(exp_addr(i, row));
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [9:0] y);
    line_start = 1'b1;
    line_y = y;
    step();
    line_start = 1'b0;
  endtask

  // follow a fetch to completion, checking each requested address
  task automatic run_fetch(input int row, input int first_slot, output int cycles);
    int n;
    n = first_slot;
    cycles = 0;
    for (int k = 0; k < 60 && fetch_busy; k++) begin
      if (rom_en) begin
        tests_run++;
        if (rom_addr !== exp_addr(n, row)) begin
          tests_failed++;
          $display("FAIL fetch_addr slot %0d: got %h expected %h", n, rom_addr, exp_addr(n, row));
        end
        if (rom_gnt) n++;
      end
      cycles++;
      step();
    end
    tests_run++;
    if (fetch_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL fetch_timeout: got busy=%b expected 0", fetch_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    tests_run++;
    if ({rom_en, fetch_busy, line_active, overrun} !== 4'b0000 || row_bits !== '0 || rom_addr !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%b busy=%b act=%b ovr=%b bits=%h addr=%h expected all 0",
               rom_en, fetch_busy, line_active, overrun, row_bits, rom_addr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch_row0();
    int n;
    for (int i = 0; i < NC; i++) begin
      base_tb[i] = {6'(5 + 3 * i), 3'b000};
      slot_wr_en = 1'b1;
      slot_wr_idx = 4'(i);
      slot_wr_base = base_tb[i] | 9'(i % 8);
      step();
    end
    slot_wr_idx = 4'd9;
    slot_wr_base = 9'h1F8;
    step();
    slot_wr_en = 1'b0;
    pulse(10'd32);
    tests_run++;
    if (rom_en !== 1'b1 || rom_addr !== 9'h028 || fetch_busy !== 1'b1 || line_active !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_req: got en=%b addr=%h busy=%b act=%b expected 1 028 1 0",
               rom_en, rom_addr, fetch_busy, line_active);
    end
    run_fetch(0, 0, n);
    tests_run++;
    if (n != NC + 1) begin
      tests_failed++;
      $display("FAIL busy_len: got %0d expected %0d", n, NC + 1);
    end
    pulse(10'd40);
    tests_run++;
    if (line_active !== 1'b1 || row_bits !== exp_bits(0)) begin
      tests_failed++;
      $display("FAIL swap_row0: got act=%b bits=%h expected 1 %h", line_active, row_bits, exp_bits(0));
    end
    run_fetch(2, 0, n);
  endtask

  task automatic test_row_calc();
    int n;
    pulse(10'd50);
    tests_run++;
    if (rom_addr !== 9'h02C || row_bits !== exp_bits(2)) begin
      tests_failed++;
      $display("FAIL row4_addr: got addr=%h bits=%h expected 02c %h", rom_addr, row_bits, exp_bits(2));
    end
    run_fetch(4, 0, n);
    pulse(10'd63);
    tests_run++;
    if (rom_addr !== 9'h02F || row_bits !== exp_bits(4)) begin
      tests_failed++;
      $display("FAIL row7_addr: got addr=%h bits=%h expected 02f %h", rom_addr, row_bits, exp_bits(4));
    end
    run_fetch(7, 0, n);
    pulse(10'd64);
    tests_run++;
    if (rom_en !== 1'b0 || fetch_busy !== 1'b0 || line_active !== 1'b1 || row_bits !== exp_bits(7)) begin
      tests_failed++;
      $display("FAIL outside_64: got en=%b busy=%b act=%b bits=%h expected 0 0 1 %h",
               rom_en, fetch_busy, line_active, row_bits, exp_bits(7));
    end
    step();
    pulse(10'd31);
    tests_run++;
    if (line_active !== 1'b0 || rom_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL outside_inactive: got act=%b en=%b expected 0 0", line_active, rom_en);
    end
  endtask

  task automatic test_stall();
    int n;
    pulse(10'd36);
    step();
    step();
    rom_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (rom_en !== 1'b1 || rom_addr !== exp_addr(2, 1)) begin
        tests_failed++;
        $display("FAIL stall_hold %0d: got en=%b addr=%h expected 1 %h", k, rom_en, rom_addr, exp_addr(2, 1));
      end
      step();
    end
    rom_gnt = 1'b1;
    run_fetch(1, 2, n);
    pulse(10'd200);
    tests_run++;
    if (line_active !== 1'b1 || row_bits !== exp_bits(1)) begin
      tests_failed++;
      $display("FAIL stall_lanes: got act=%b bits=%h expected 1 %h", line_active, row_bits, exp_bits(1));
    end
  endtask

  task automatic test_overrun();
    int n;
    logic [NC*8-1:0] front_before;
    front_before = row_bits;
    pulse(10'd44);
    step();
    step();
    step();
    pulse(10'd48);
    tests_run++;
    if (overrun !== 1'b1 || line_active !== 1'b0 || row_bits !== front_before) begin
      tests_failed++;
      $display("FAIL overrun_noswap: got ovr=%b act=%b bits=%h expected 1 0 %h",
               overrun, line_active, row_bits, front_before);
    end
    tests_run++;
    if (rom_en !== 1'b1 || fetch_busy !== 1'b1 || rom_addr !== exp_addr(0, 4)) begin
      tests_failed++;
      $display("FAIL overrun_restart: got en=%b busy=%b addr=%h expected 1 1 %h",
               rom_en, fetch_busy, rom_addr, exp_addr(0, 4));
    end
    run_fetch(4, 0, n);
    tests_run++;
    if (n != NC + 1) begin
      tests_failed++;
      $display("FAIL overrun_len: got %0d expected %0d", n, NC + 1);
    end
    pulse(10'd100);
    tests_run++;
    if (line_active !== 1'b1 || row_bits !== exp_bits(4) || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_after: got act=%b ovr=%b bits=%h expected 1 1 %h",
               line_active, overrun, row_bits, exp_bits(4));
    end
  endtask

  task automatic test_reset_mid();
    int n;
    pulse(10'd32);
    step();
    step();
    rst = 1'b1;
    step();
    tests_run++;
    if ({rom_en, fetch_busy, line_active, overrun} !== 4'b0000 || row_bits !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: got en=%b busy=%b act=%b ovr=%b bits=%h expected all 0",
               rom_en, fetch_busy, line_active, overrun, row_bits);
    end
    rst = 1'b0;
    for (int i = 0; i < NC; i++) base_tb[i] = 9'd0;
    step();
    pulse(10'd32);
    run_fetch(0, 0, n);
    pulse(10'd200);
    tests_run++;
    if (row_bits !== exp_bits(0) || line_active !== 1'b1) begin
      tests_failed++;
      $display("FAIL slots_cleared: got act=%b bits=%h expected 1 %h", line_active, row_bits, exp_bits(0));
    end
  endtask

`ifdef CHAR_FETCH_OVERRUN_CNT_EN
  task automatic test_overrun_cnt();
    pulse(10'd32);
    for (int k = 0; k < 300; k++) begin
      step();
      pulse(10'd32);
    end
    tests_run++;
    if (overrun_cnt !== 8'd255 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL cnt_saturate: got cnt=%0d ovr=%b expected 255 1", overrun_cnt, overrun);
    end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    tests_run++;
    if (overrun_cnt !== 8'd0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL cnt_clear: got cnt=%0d ovr=%b expected 0 0", overrun_cnt, overrun);
    end
    overrun_clr = 1'b1;
    pulse(10'd32);
    overrun_clr = 1'b0;
    tests_run++;
    if (overrun_cnt !== 8'd0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL cnt_clear_wins: got cnt=%0d ovr=%b expected 0 0", overrun_cnt, overrun);
    end
    step();
    pulse(10'd32);
    tests_run++;
    if (overrun_cnt !== 8'd1 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL cnt_one: got cnt=%0d ovr=%b expected 1 1", overrun_cnt, overrun);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NC; i++) base_tb[i] = 9'd0;
    test_reset();
    test_fetch_row0();
    test_row_calc();
    test_stall();
    test_overrun();
    test_reset_mid();
`ifdef CHAR_FETCH_OVERRUN_CNT_EN
    test_overrun_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
